// File: rtl/lock_code_sender.sv
// rtl/lock_code_sender.sv - six-digit door-lock code transmitter over a valid/ready digit channel
// Holds a reprogrammable code and plays it out one digit per transfer, with a 7-segment status display.
module lock_code_sender #(
    parameter logic [23:0] DEFAULT_CODE = 24'h825432
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_valid,
    output logic       busy,
    output logic       done,
    output logic       load_err,
    output logic [2:0] index,
    output logic [6:0] hex_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] code_q [0:5];
    logic [3:0] code_d [0:5];
    logic [2:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] index_q, index_d;
    logic       load_err_q, load_err_d;
    logic [3:0] out_digit_q, out_digit_d;
    logic       out_valid_q, busy_q, done_q;
    logic [6:0] hex_q, hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        wr_ptr_d   = wr_ptr_q;
        index_d    = index_q;
        load_err_d = load_err_q;
        case (state_q)
            SEND: begin
                if (out_ready) begin
                    if (index_q == 3'd5) begin
                        state_d = DONE;
                        index_d = 3'd0;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end
            end
            default: begin
                // load has priority over start, even when the digit is rejected
                if (load) begin
                    if (load_digit <= 4'd9) begin
                        code_d[wr_ptr_q] = load_digit;
                        wr_ptr_d         = (wr_ptr_q == 3'd5) ? 3'd0 : wr_ptr_q + 3'd1;
                        load_err_d       = 1'b0;
                        state_d          = IDLE;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (start) begin
                    state_d = SEND;
                    index_d = 3'd0;
                end
            end
        endcase

        out_digit_d = (state_d == SEND) ? code_d[index_d] : 4'd0;
        case (state_d)
            SEND:    hex_d = seg7(out_digit_d);
            DONE:    hex_d = 7'b0001100;
            default: hex_d = load_err_d ? 7'b0000110 : 7'b1111111;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < 6; i++) begin
                code_q[i] <= DEFAULT_CODE[23-4*i -: 4];
            end
            wr_ptr_q    <= 3'd0;
            index_q     <= 3'd0;
            load_err_q  <= 1'b0;
            out_digit_q <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hex_q       <= 7'b1111111;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            wr_ptr_q    <= wr_ptr_d;
            index_q     <= index_d;
            load_err_q  <= load_err_d;
            out_digit_q <= out_digit_d;
            out_valid_q <= (state_d == SEND);
            busy_q      <= (state_d == SEND);
            done_q      <= (state_d == DONE);
            hex_q       <= hex_d;
        end
    end

    assign out_digit = out_digit_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign load_err  = load_err_q;
    assign index     = index_q;
    assign hex_out   = hex_q;

endmodule

// File: doc/lock_code_sender.md
# lock_code_sender

Synchronous combination transmitter for the lab 3 door-lock. It holds a six-digit code and plays it out one decimal digit per accepted transfer on a valid/ready channel. That channel drives the lock's digit input, one digit per lock clock, so the lock FSM can be exercised on the board or in simulation. The stored code can be reprogrammed digit by digit, and the current digit is shown on a seven-segment display.

## Interface
- DEFAULT_CODE, 24'h825432, reset value of the code register; the most significant nibble is digit 0 (first sent).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  request to play the stored code; single-cycle pulse or level.
- load  input  1  write load_digit into the code register at the write pointer.
- load_digit  input  4  digit to store; legal range 0–9.
- out_ready  input  1  sink accepts out_digit this cycle.
- out_digit  output  4  digit being offered; code[index] while sending, 0 otherwise.
- out_valid  output  1  out_digit is valid.
- busy  output  1  high in SEND.
- done  output  1  high in DONE.
- load_err  output  1  sticky flag: last load attempt was out of range.
- index  output  3  position of the digit being offered, 0–5.
- hex_out  output  7  active-low segments {g..a}.

## Operation
- Storage: code[0..5] (4 bits each); write pointer wr_ptr (0–5).
- FSM states:
  - IDLE (encoding 2'b00)
  - SEND (2'b01)
  - DONE (2'b10)
- Reset values:
  - state = IDLE; code = DEFAULT_CODE; wr_ptr = 0; index = 0.
  - out_valid = 0; out_digit = 0; busy = 0; done = 0; load_err = 0; hex_out = 7'b1111111.
- Load (accepted only in IDLE or DONE):
  - If load_digit ≤ 9: code[wr_ptr] ← load_digit; wr_ptr increments, wrapping 5→0; load_err ← 0; in DONE, state → IDLE.
  - If load_digit > 9: no write; wr_ptr and state unchanged; load_err ← 1.
  - Load asserted in SEND is ignored.
- Start: in IDLE or DONE with load = 0, the state goes to SEND and index ← 0.
  - If load and start are asserted together, load wins and start is ignored.
  - Start asserted in SEND is ignored.
- SEND:
  - out_valid = 1 and out_digit = code[index].
  - A transfer occurs on any edge where out_valid && out_ready.
  - On a transfer with index < 5: index increments.
  - On a transfer with index = 5: state → DONE and index ← 0.
  - With out_ready low, out_digit, index and out_valid hold indefinitely.
- DONE: done = 1 and out_valid = 0. The block stays in DONE until start (replay) or a valid load.
- hex_out:
  - SEND: the decimal pattern of out_digit. 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - DONE: letter P (0001100).
  - IDLE with load_err = 1: letter E (0000110).
  - IDLE otherwise: blank (1111111).
- Reset asserted mid-SEND: the next edge forces all reset values, including the code register. No partial sequence continues.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Start sampled at edge N: out_valid = 1 and index = 0 after edge N.
- With out_ready held high: one digit per cycle. The last transfer occurs at edge N+6; done = 1 and busy = 0 after edge N+6.
- Each low cycle of out_ready adds exactly one cycle of latency.
- A load takes effect at the edge where it is sampled; a start in the following cycle sends the new value.
- Back-to-back starts: start in DONE at edge M restarts SEND with index = 0 after edge M.

## Test plan
- Reset, then start with out_ready = 1:
  - out_digit sequence is 8, 2, 5, 4, 3, 2 on consecutive cycles, index 0–5.
  - done = 1 after the 6th transfer.
  - hex_out shows 0000000 for the first digit, then P in DONE.
- Load 1, 2, 3, 4, 5, 6, then start: sequence is 1, 2, 3, 4, 5, 6. Load 7 next: wr_ptr has wrapped, so code[0] = 7 and the sequence is 7, 2, 3, 4, 5, 6.
- Load 12 in IDLE:
  - load_err = 1, hex_out = 0000110, code unchanged.
  - A following load of 9 clears load_err and writes code[wr_ptr].
- During SEND, drop out_ready for 3 cycles at index 2:
  - out_digit holds 5 and index holds 2 for those cycles; load and start are ignored.
  - Completion is 3 cycles later than the unstalled case.
- Assert reset at index 3 after loading a custom code:
  - Next cycle state = IDLE, out_valid = 0, code = 825432.
  - A subsequent start sends 8, 2, 5, 4, 3, 2.
- Assert load and start together in DONE with load_digit = 0: code written, state → IDLE, no send starts.
